// File: rtl/spider_spawn_ctrl.sv
// rtl/spider_spawn_ctrl.sv - spider hazard placement, collision and respawn sequencer
module spider_spawn_ctrl #(
  parameter int          NUM_SPIDERS   = 5,
  parameter int          RESPAWN_TICKS = 60,
  parameter int          GRID_STEP     = 20,
  parameter int          X_ORG         = 20,
  parameter int          Y_ORG         = 20,
  parameter int          PARK_XY       = 700,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      game_start,
  input  logic                      game_stop,
  input  logic                      tick,
  input  logic [11:0]               snake_x,
  input  logic [11:0]               snake_y,
  output logic [12*NUM_SPIDERS-1:0] spider_x,
  output logic [12*NUM_SPIDERS-1:0] spider_y,
  output logic [NUM_SPIDERS-1:0]    spider_valid,
  output logic                      spider_hit,
  output logic [2:0]                hit_idx,
  output logic [7:0]                hit_count,
  output logic                      busy
);
  typedef enum logic [1:0] {IDLE, PLACE, ACTIVE} state_t;

  localparam logic [11:0]               PARK     = 12'(PARK_XY);
  localparam logic [7:0]                RELOAD   = 8'(RESPAWN_TICKS);
  localparam logic [12*NUM_SPIDERS-1:0] PARK_ALL = {NUM_SPIDERS{PARK}};

  state_t                 state;
  logic [15:0]            lfsr;
  logic [15:0]            lfsr_next;
  logic [7:0]             timer [NUM_SPIDERS];
  logic [NUM_SPIDERS-1:0] pending;
  logic [NUM_SPIDERS-1:0] pending_next;
  logic [NUM_SPIDERS-1:0] expire;
  logic [11:0]            cand_x;
  logic [11:0]            cand_y;
  logic                   cand_clash;
  logic                   hit_any;
  logic                   place_any;
  logic                   place_ok;
  logic [2:0]             hit_slot;
  logic [2:0]             place_slot;

  assign lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
  assign cand_x    = 12'(X_ORG) + 12'(GRID_STEP) * {7'd0, lfsr[4:0]};
  assign cand_y    = 12'(Y_ORG) + 12'(GRID_STEP) * {7'd0, lfsr[9:5]};

  // Descending scan so the lowest matching / pending index wins.
  always_comb begin
    hit_any    = 1'b0;
    hit_slot   = '0;
    place_any  = 1'b0;
    place_slot = '0;
    expire     = '0;
    cand_clash = (cand_x == snake_x) && (cand_y == snake_y);
    for (int i = NUM_SPIDERS - 1; i >= 0; i--) begin
      if (spider_valid[i] && (spider_x[12*i +: 12] == snake_x) &&
          (spider_y[12*i +: 12] == snake_y)) begin
        hit_any  = 1'b1;
        hit_slot = 3'(i);
      end
      if (pending[i]) begin
        place_any  = 1'b1;
        place_slot = 3'(i);
      end
      if (spider_valid[i] && (spider_x[12*i +: 12] == cand_x) &&
          (spider_y[12*i +: 12] == cand_y)) begin
        cand_clash = 1'b1;
      end
      expire[i] = tick && (timer[i] == 8'd1);
    end
    place_ok     = (state == PLACE) && place_any && !cand_clash;
    pending_next = pending | expire;
    if (place_ok) begin
      pending_next[place_slot] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      lfsr         <= LFSR_SEED;
      spider_x     <= PARK_ALL;
      spider_y     <= PARK_ALL;
      spider_valid <= '0;
      spider_hit   <= 1'b0;
      hit_idx      <= '0;
      hit_count    <= '0;
      pending      <= '0;
      busy         <= 1'b0;
      for (int i = 0; i < NUM_SPIDERS; i++) timer[i] <= '0;
    end else begin
      lfsr       <= lfsr_next;
      spider_hit <= 1'b0;
      if (game_stop) begin
        // A hit detected this cycle is dropped along with the round.
        state        <= IDLE;
        busy         <= 1'b0;
        spider_x     <= PARK_ALL;
        spider_y     <= PARK_ALL;
        spider_valid <= '0;
        pending      <= '0;
        for (int i = 0; i < NUM_SPIDERS; i++) timer[i] <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (game_start) begin
              state     <= PLACE;
              busy      <= 1'b1;
              hit_count <= '0;
              pending   <= '1;
              for (int i = 0; i < NUM_SPIDERS; i++) timer[i] <= '0;
            end
          end
          PLACE, ACTIVE: begin
            pending <= pending_next;
            state   <= (pending_next != '0) ? PLACE : ACTIVE;
            busy    <= (pending_next != '0);
            if (hit_any) begin
              spider_hit <= 1'b1;
              hit_idx    <= hit_slot;
              if (hit_count != 8'hFF) hit_count <= hit_count + 8'd1;
            end
            for (int i = 0; i < NUM_SPIDERS; i++) begin
              if (hit_any && (hit_slot == 3'(i))) begin
                spider_valid[i]      <= 1'b0;
                spider_x[12*i +: 12] <= PARK;
                spider_y[12*i +: 12] <= PARK;
                timer[i]             <= RELOAD;
              end else begin
                if (place_ok && (place_slot == 3'(i))) begin
                  spider_valid[i]      <= 1'b1;
                  spider_x[12*i +: 12] <= cand_x;
                  spider_y[12*i +: 12] <= cand_y;
                end
                if (tick && (timer[i] != 8'd0)) timer[i] <= timer[i] - 8'd1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spider_spawn_ctrl.sv
// tb/tb_spider_spawn_ctrl.sv - directed self-checking bench for spider_spawn_ctrl
module tb_spider_spawn_ctrl;
  localparam logic [59:0] PARK_ALL = {5{12'd700}};

  logic        clk = 1'b0;
  logic        reset;
  logic        game_start;
  logic        game_stop;
  logic        tick;
  logic [11:0] snake_x;
  logic [11:0] snake_y;
  logic [59:0] spider_x;
  logic [59:0] spider_y;
  logic [4:0]  spider_valid;
  logic        spider_hit;
  logic [2:0]  hit_idx;
  logic [7:0]  hit_count;
  logic        busy;

  spider_spawn_ctrl dut (
    .clk(clk), .reset(reset), .game_start(game_start), .game_stop(game_stop),
    .tick(tick), .snake_x(snake_x), .snake_y(snake_y),
    .spider_x(spider_x), .spider_y(spider_y), .spider_valid(spider_valid),
    .spider_hit(spider_hit), .hit_idx(hit_idx), .hit_count(hit_count), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          slot;
    logic [11:0] x;
    logic [11:0] y;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          failures = 0;
  logic [15:0] m_lfsr;
  logic [4:0]  mpend;
  logic [4:0]  mvalid;
  logic [59:0] mxp;
  logic [59:0] myp;

  // Independent LFSR model, stepped on the same edges as the design.
  always @(posedge clk or posedge reset) begin
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int lowest(input logic [4:0] v);
    int r = 0;
    for (int i = 4; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  task automatic pulse(input logic s, input logic p);
    @(negedge clk);
    game_start = s;
    game_stop  = p;
    @(negedge clk);
    game_start = 1'b0;
    game_stop  = 1'b0;
  endtask

  // Predicts each placement from the LFSR model; optionally parks the snake
  // on the next force_n candidates to make the design reject them.
  task automatic place_loop(input int force_n, input int max_cyc, output int cyc, output int forced);
    exp_t got;
    cyc    = 0;
    forced = 0;
    while (mpend != 5'd0 && cyc < max_cyc) begin
      int          s;
      logic [11:0] cx;
      logic [11:0] cy;
      logic        clash;
      exp_t        e;
      s  = lowest(mpend);
      cx = 12'd20 + 12'd20 * {7'd0, m_lfsr[4:0]};
      cy = 12'd20 + 12'd20 * {7'd0, m_lfsr[9:5]};
      clash = 1'b0;
      for (int j = 0; j < 5; j++)
        if (mvalid[j] && mxp[12*j +: 12] == cx && myp[12*j +: 12] == cy) clash = 1'b1;
      if (forced < force_n && !clash) begin
        snake_x = cx;
        snake_y = cy;
        forced++;
      end else begin
        snake_x = 12'd0;
        snake_y = 12'd0;
      end
      if (cx == snake_x && cy == snake_y) clash = 1'b1;
      if (!clash) begin
        e.slot = s; e.x = cx; e.y = cy;
        sbq.push_back(e);
        mvalid[s] = 1'b1;
        mxp[12*s +: 12] = cx;
        myp[12*s +: 12] = cy;
        mpend[s] = 1'b0;
      end
      chk("busy_in_place", 64'(busy), 64'd1);
      @(negedge clk);
      cyc++;
      if (!clash) begin
        got = sbq.pop_front();
        chk($sformatf("place_x%0d", got.slot), 64'(spider_x[12*got.slot +: 12]), 64'(got.x));
        chk($sformatf("place_y%0d", got.slot), 64'(spider_y[12*got.slot +: 12]), 64'(got.y));
      end
      chk("valid_in_place", 64'(spider_valid), 64'(mvalid));
    end
    snake_x = 12'd0;
    snake_y = 12'd0;
  endtask

  initial begin
    int   cyc;
    int   forced;
    int   pulses;
    int   hits;
    int   waited;
    exp_t got;
    exp_t e;
    logic ok;

    reset = 1'b1; game_start = 1'b0; game_stop = 1'b0; tick = 1'b0;
    snake_x = 12'd0; snake_y = 12'd0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(spider_valid), 64'd0);
    chk("rst_x", 64'(spider_x), 64'(PARK_ALL));
    chk("rst_y", 64'(spider_y), 64'(PARK_ALL));
    chk("rst_hit", 64'(spider_hit), 64'd0);
    chk("rst_hit_idx", 64'(hit_idx), 64'd0);
    chk("rst_hit_count", 64'(hit_count), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    reset = 1'b0;

    // Round start with the snake at the origin.
    pulse(1'b1, 1'b0);
    mpend = 5'h1F; mvalid = 5'h00; mxp = PARK_ALL; myp = PARK_ALL;
    chk("start_hit_count", 64'(hit_count), 64'd0);
    place_loop(0, 100, cyc, forced);
    chk("place_all_done", 64'(mpend), 64'd0);
    chk("busy_len_ge5", 64'(cyc >= 5), 64'd1);
    @(negedge clk);
    chk("busy_after_place", 64'(busy), 64'd0);
    chk("valid_all", 64'(spider_valid), 64'h1F);
    for (int i = 0; i < 5; i++) begin
      ok = 1'b1;
      if (spider_x[12*i +: 12] < 12'd20 || spider_x[12*i +: 12] > 12'd640 || (spider_x[12*i +: 12] % 20) != 0) ok = 1'b0;
      if (spider_y[12*i +: 12] < 12'd20 || spider_y[12*i +: 12] > 12'd640 || (spider_y[12*i +: 12] % 20) != 0) ok = 1'b0;
      for (int j = 0; j < i; j++)
        if (spider_x[12*i +: 12] == spider_x[12*j +: 12] && spider_y[12*i +: 12] == spider_y[12*j +: 12]) ok = 1'b0;
      chk($sformatf("grid_distinct%0d", i), 64'(ok), 64'd1);
    end

    // Hold the head on slot 2 for three cycles: one hit only.
    snake_x = mxp[24 +: 12]; snake_y = myp[24 +: 12];
    e.slot = 2; e.x = 12'd700; e.y = 12'd700;
    sbq.push_back(e);
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 2) begin snake_x = 12'd0; snake_y = 12'd0; end
      if (spider_hit) begin
        pulses++;
        if (sbq.size() != 0) begin
          got = sbq.pop_front();
          chk("hit_idx", 64'(hit_idx), 64'(got.slot));
        end
      end
    end
    chk("hit_pulses", 64'(pulses), 64'd1);
    chk("hit_sb_empty", 64'(sbq.size()), 64'd0);
    mvalid[2] = 1'b0; mxp[24 +: 12] = 12'd700; myp[24 +: 12] = 12'd700;
    chk("hit_valid", 64'(spider_valid), 64'h1B);
    chk("hit_park_x", 64'(spider_x[24 +: 12]), 64'd700);
    chk("hit_park_y", 64'(spider_y[24 +: 12]), 64'd700);
    chk("hit_count1", 64'(hit_count), 64'd1);

    // Respawn after exactly 60 ticks, with forced candidate rejections.
    for (int t = 0; t < 59; t++) begin
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0;
    end
    chk("tick59_valid", 64'(spider_valid), 64'h1B);
    chk("tick59_busy", 64'(busy), 64'd0);
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    chk("tick60_busy", 64'(busy), 64'd1);
    mpend = 5'b00100;
    place_loop(4, 100, cyc, forced);
    chk("respawn_done", 64'(mpend), 64'd0);
    chk("forced_rejects", 64'(forced >= 1), 64'd1);
    @(negedge clk);
    chk("respawn_valid", 64'(spider_valid), 64'h1F);

    // game_start while ACTIVE is ignored.
    pulse(1'b1, 1'b0);
    chk("start_active_busy", 64'(busy), 64'd0);
    chk("start_active_x", 64'(spider_x), 64'(mxp));
    chk("start_active_y", 64'(spider_y), 64'(myp));
    chk("start_active_hc", 64'(hit_count), 64'd1);

    // game_stop from ACTIVE parks everything, hit_count holds.
    pulse(1'b0, 1'b1);
    chk("stop_valid", 64'(spider_valid), 64'd0);
    chk("stop_x", 64'(spider_x), 64'(PARK_ALL));
    chk("stop_hc", 64'(hit_count), 64'd1);
    pulse(1'b1, 1'b1);
    chk("stop_prio_busy", 64'(busy), 64'd0);

    // Stop in the middle of PLACE.
    pulse(1'b1, 1'b0);
    mpend = 5'h1F; mvalid = 5'h00; mxp = PARK_ALL; myp = PARK_ALL;
    chk("restart_hc", 64'(hit_count), 64'd0);
    place_loop(0, 2, cyc, forced);
    pulse(1'b0, 1'b1);
    mpend = 5'h00; mvalid = 5'h00; mxp = PARK_ALL; myp = PARK_ALL;
    chk("midstop_busy", 64'(busy), 64'd0);
    chk("midstop_valid", 64'(spider_valid), 64'd0);
    chk("midstop_x", 64'(spider_x), 64'(PARK_ALL));
    chk("midstop_y", 64'(spider_y), 64'(PARK_ALL));

    // Saturation: chase spiders with continuous ticks until 256 hits.
    pulse(1'b1, 1'b0);
    waited = 0;
    while (busy && waited < 200) begin @(negedge clk); waited++; end
    chk("sat_place_timeout", 64'(busy), 64'd0);
    tick = 1'b1;
    hits = 0;
    for (int c = 0; c < 20000 && hits < 256; c++) begin
      snake_x = 12'd0; snake_y = 12'd0;
      for (int j = 4; j >= 0; j--)
        if (spider_valid[j]) begin
          snake_x = spider_x[12*j +: 12];
          snake_y = spider_y[12*j +: 12];
        end
      @(negedge clk);
      if (spider_hit) begin
        hits++;
        if (hits == 200) chk("hc_200", 64'(hit_count), 64'd200);
        if (hits == 255) chk("hc_255", 64'(hit_count), 64'd255);
      end
    end
    chk("sat_hits_reached", 64'(hits), 64'd256);
    chk("hc_saturated", 64'(hit_count), 64'd255);
    snake_x = 12'd0; snake_y = 12'd0;
    waited = 0;
    while (spider_valid != 5'h1F && waited < 400) begin @(negedge clk); waited++; end
    chk("refill_timeout", 64'(spider_valid), 64'h1F);
    tick = 1'b0;

    // Reset asserted while the hit pulse is high.
    snake_x = spider_x[11:0]; snake_y = spider_y[11:0];
    @(posedge clk); #1;
    chk("pre_rst_hit", 64'(spider_hit), 64'd1);
    reset = 1'b1;
    #1;
    chk("async_rst_hit", 64'(spider_hit), 64'd0);
    chk("async_rst_valid", 64'(spider_valid), 64'd0);
    chk("async_rst_hc", 64'(hit_count), 64'd0);
    chk("async_rst_x", 64'(spider_x), 64'(PARK_ALL));
    chk("async_rst_y", 64'(spider_y), 64'(PARK_ALL));
    chk("async_rst_busy", 64'(busy), 64'd0);
    chk("async_rst_idx", 64'(hit_idx), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
